// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter
// Round-robin arbiter and sequencer for a shared tri-state bus. Each grant
// opens with one TURN cycle where the grantee is selected but nobody drives,
// so two drivers never overlap on the resolved bus.
//
// Optional feature: define TRI_ARB_TIMEOUT_EN to limit each tenure to
// HOLD_MAX consecutive OWN cycles. When it is undefined there is no hold
// counter and timeout is tied low.
module tri_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         drv_en,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     owner_vld,
    output logic                     timeout
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TURN = 2'd1;
    localparam logic [1:0] S_OWN  = 2'd2;

    logic [1:0]       state_reg;
    logic [N_REQ-1:0] grant_reg;
    logic [N_REQ-1:0] drv_en_reg;
    logic [IDW-1:0]   owner_reg;
    logic [IDW-1:0]   ptr_reg;

    logic [IDW-1:0]   arb_base;
    logic             win_vld;
    logic [IDW-1:0]   win_idx;
    logic [N_REQ-1:0] win_onehot;

    logic             owner_req;
    logic             hold_expired;
    logic             forced_rel;
    logic             release_now;

    assign owner_req = req[owner_reg];

    // Arbitrate from the pointer when idle; on release the releasing owner
    // becomes the new pointer, so it is scanned last.
    always_comb begin
        arb_base = (state_reg == S_OWN) ? owner_reg : ptr_reg;
        win_vld  = 1'b0;
        win_idx  = '0;
        // Walk from the farthest offset back to the nearest one so the first
        // set bit after the base is the one left standing.
        for (int i = N_REQ; i >= 1; i--) begin
            int unsigned idx;
            idx = (int'(arb_base) + i) % N_REQ;
            if (req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx[IDW-1:0];
            end
        end
    end

    // One-hot form of the winning index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_win_onehot
            assign win_onehot[gi] = win_vld && (win_idx == IDW'(gi));
        end
    endgenerate

`ifdef TRI_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);

    logic [HW-1:0] hold_cnt_reg;
    logic          timeout_reg;

    // hold_cnt is the number of completed OWN cycles in this tenure; the
    // tenure expires at the end of its HOLD_MAX-th cycle.
    assign hold_expired = (hold_cnt_reg == HW'(HOLD_MAX - 1));

    // Count OWN cycles; cleared on the edge that enters OWN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == S_TURN && owner_req) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == S_OWN && !release_now) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
    end

    // Pulse timeout in the first cycle after a forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= forced_rel;
        end
    end

    assign timeout = timeout_reg;
`else
    // Tenure never expires; HOLD_MAX has no effect in this build.
    assign hold_expired = 1'b0 && (HOLD_MAX > 0);
    assign timeout      = 1'b0;
`endif

    // A release forced by expiry only counts as forced if the owner still wants the bus.
    assign forced_rel  = (state_reg == S_OWN) && owner_req && hold_expired;
    assign release_now = (state_reg == S_OWN) && (!owner_req || hold_expired);

    // Main sequencer: IDLE -> TURN (granted, not driving) -> OWN (driving).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            grant_reg  <= '0;
            drv_en_reg <= '0;
            owner_reg  <= '0;
            ptr_reg    <= IDW'(N_REQ - 1);
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (win_vld) begin
                        grant_reg <= win_onehot;
                        owner_reg <= win_idx;
                        state_reg <= S_TURN;
                    end
                end
                S_TURN: begin
                    if (owner_req) begin
                        drv_en_reg <= grant_reg;
                        state_reg  <= S_OWN;
                    end else begin
                        // Withdrawn during turnaround: drop it without moving ptr.
                        grant_reg <= '0;
                        state_reg <= S_IDLE;
                    end
                end
                S_OWN: begin
                    if (release_now) begin
                        drv_en_reg <= '0;
                        ptr_reg    <= owner_reg;
                        if (win_vld) begin
                            grant_reg <= win_onehot;
                            owner_reg <= win_idx;
                            state_reg <= S_TURN;
                        end else begin
                            grant_reg <= '0;
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: begin
                    grant_reg  <= '0;
                    drv_en_reg <= '0;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_reg;
    assign drv_en    = drv_en_reg;
    assign owner_id  = owner_reg;
    assign owner_vld = |drv_en_reg;

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared tri-state bus. Each of N_REQ drivers places data on the bus only while its drv_en bit is high.
- Drives one-hot driver enables so that at most one driver is active.
- Inserts a turnaround cycle with no driver between owners, so the resolved bus never sees contention.
- Sits between bus masters and the tri-state driver wiring; the drivers use the `en ? data : 'z` form.

Parameters:
- N_REQ, 4: number of requesters/drivers, at least 2.
- HOLD_MAX, 8: maximum consecutive OWN cycles per tenure. Used only with TRI_ARB_TIMEOUT_EN. At least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  level requests; a requester holds its bit high for as long as it wants the bus.
- grant  out  N_REQ  one-hot0 registered grant; high in TURN and OWN.
- drv_en  out  N_REQ  one-hot0 tri-state enable; high only in OWN.
- owner_id  out  $clog2(N_REQ)  index of the current grantee; holds the last value when idle.
- owner_vld  out  1  equals |drv_en.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async): state=IDLE, grant=0, drv_en=0, owner_id=0, timeout=0, ptr=N_REQ-1, hold_cnt=0.
  - All enables drop immediately with no clock edge, so the bus floats.
- States:
  - IDLE: no grant. If |req, pick the winner k, set grant=onehot(k) and owner_id=k, go to TURN. Otherwise stay.
  - TURN: grant=onehot(k), drv_en=0.
    - If req[k]=1: go to OWN and set drv_en[k] at that edge.
    - If req[k]=0 (withdrawn): clear grant, go to IDLE, leave ptr unchanged.
  - OWN: drv_en[k]=1. Release occurs when req[k]=0 or a timeout fires. On release:
    - drv_en=0 and ptr=k at the same edge.
    - If any other req bit is set: re-arbitrate from the new ptr, grant the new winner, go to TURN.
    - Otherwise clear grant and go to IDLE.
- Round-robin winner: first set bit scanning indices ptr+1, ptr+2, … modulo N_REQ.
  - After reset, index 0 has highest priority.
  - On a release, the releasing requester is scanned last. If it is the only requester, it is regranted after TURN.
- Latency:
  - req rising before edge E0 in IDLE: grant after E0, drv_en after E1.
  - Handover: between the last drv_en of owner A and the first drv_en of owner B there is exactly one cycle with drv_en=0.
- Simultaneous events:
  - A req change in the same cycle as a decision is sampled at that edge only.
  - In OWN, requests from non-owners have no effect until release.
- Invariants, checked every cycle:
  - drv_en is onehot0.
  - drv_en & ~grant == 0.
  - owner_vld == |drv_en.
  - No edge takes drv_en from one nonzero value to a different nonzero value.

Optional Feature:
- Macro TRI_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt counts OWN cycles, width $clog2(HOLD_MAX+1).
  - After HOLD_MAX OWN cycles the owner is force-released. This follows the same release path, with timeout=1 for one cycle coinciding with the first cycle after release.
  - hold_cnt clears on entering OWN.
- Undefined:
  - No counter is built and timeout is tied to 0.
  - Tenure is unlimited while req[k] stays high.

Test Plan (N_REQ=4, HOLD_MAX=4):
1. Reset, then req=0001 before E0, dropped after E4:
   - grant=0001 after E0, drv_en=0001 after E1.
   - drv_en=0 and grant=0 one edge after req is seen low.
   - owner_id=0 throughout.
2. req=1111; each owner drops its req after 3 OWN cycles and does not re-request:
   - grants 0001, 0010, 0100, 1000 in order.
   - Exactly one drv_en=0 cycle between tenures; invariants hold throughout.
3. TRI_ARB_TIMEOUT_EN defined, req=0011 held high:
   - owner 0 drives 4 cycles, then timeout pulses, then TURN, then owner 1 drives 4 cycles, then timeout, then owner 0 again. Alternation continues.
4. req=0100 rises then falls during TURN:
   - grant=0100 for one cycle, drv_en never set, returns to IDLE.
   - A later req=0110 grants index 1 first, because ptr is unchanged.
5. rst_n pulled low mid-OWN between clock edges:
   - drv_en and grant go to 0 immediately.
   - After rst_n release with req=1111, the first grant is 0001.
6. Macro undefined, req=1000 held for 100 cycles with other requests arriving:
   - drv_en=1000 continuously, timeout stays 0.
   - After req[3] drops, index 0 wins next.
